// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: widths, state encoding, op-select
// indices used by the ALU decode, and sign-magnitude helpers.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_BUSY = DIV_BUSY,
    ST_DONE = DIV_DONE
  } div_state_e;

  // Bit positions of the one-hot divide op select driven by the ALU decode
  localparam int OP_DIV  = 0;
  localparam int OP_MOD  = 1;
  localparam int OP_DIVU = 2;
  localparam int OP_MODU = 3;

  function automatic logic [DIV_DATA_W-1:0] neg_if(input logic [DIV_DATA_W-1:0] v,
                                                   input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of a two's-complement value; 32'h8000_0000 maps to itself, read as unsigned
  function automatic logic [DIV_DATA_W-1:0] abs32(input logic [DIV_DATA_W-1:0] v);
    return neg_if(v, v[DIV_DATA_W-1]);
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// Divide request/complete handshake between the ALU (master) and the divider (slave).
interface iter_div_unit_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic              div;
  logic              div_signed;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] r;
  logic              complete;

  modport master (output div, div_signed, x, y, input q, r, complete);
  modport slave  (input div, div_signed, x, y, output q, r, complete);
endinterface

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, with the
// sign fix folded into the last iteration so q/r are registered at completion.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input logic            div_clk,
  input logic            resetn,
  iter_div_unit_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for div; operands are captured on the edge that sees it high
  // BUSY  | one shift/subtract per cycle; div low aborts back to IDLE
  // DONE  | complete high for one cycle, q/r valid

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, dvd_q, dvs_q;
  logic [DATA_W-1:0] q_q, r_q;
  logic              neg_q_q, neg_r_q;

  logic [DATA_W:0]   rem_sh, trial;
  logic [DATA_W-1:0] rem_nx, dvd_nx;
  logic              qbit, last;

  always_comb begin
    rem_sh = {rem_q, dvd_q[DATA_W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    qbit   = ~trial[DATA_W];
    rem_nx = qbit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    dvd_nx = {dvd_q[DATA_W-2:0], qbit};
    last   = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.div) state_d = ST_BUSY;
      ST_BUSY: begin
        if (!bus.div)  state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.div) begin
            dvd_q   <= bus.div_signed ? abs32(bus.x) : bus.x;
            dvs_q   <= bus.div_signed ? abs32(bus.y) : bus.y;
            neg_q_q <= bus.div_signed & (bus.x[DATA_W-1] ^ bus.y[DATA_W-1]);
            neg_r_q <= bus.div_signed & bus.x[DATA_W-1];
            rem_q   <= '0;
            cnt_q   <= CNT_W'(DATA_W);
          end
        end
        ST_BUSY: begin
          if (bus.div) begin
            rem_q <= rem_nx;
            dvd_q <= dvd_nx;
            cnt_q <= cnt_q - 1'b1;
            if (last) begin
              q_q <= neg_if(dvd_nx, neg_q_q);
              r_q <= neg_if(rem_nx, neg_r_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.complete = (state_q == ST_DONE);

endmodule
